// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch unit: fetch PC, single-outstanding memory reads, decode queue
// Optional feature macro: JAL_EARLY_REDIRECT_EN (JAL redirects fetch locally instead of blocking)
module inst_fetch #(
    parameter int ADDR_WIDTH = 32,
    parameter int QUEUE_DEPTH = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [31:0]           mem_rdata,
    output logic                  decoderEnable,
    output logic [31:0]           instToDecode,
    output logic [ADDR_WIDTH-1:0] inst_PC,
    input  logic                  dispatch_ready,
    input  logic                  br_resolve,
    input  logic [ADDR_WIDTH-1:0] br_target
);
    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_BLOCKED} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [ADDR_WIDTH-1:0] req_pc;
    logic                  drop;
    logic [CNT_W-1:0]      count;
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic [31:0]           q_inst [QUEUE_DEPTH];
    logic [ADDR_WIDTH-1:0] q_pc   [QUEUE_DEPTH];

    logic                  gnt_ok;
    logic                  resp;
    logic                  deq;
    logic [CNT_W-1:0]      cnt_next;
    logic                  space_ok;
    logic                  blocks;
    logic [6:0]            opcode;

    // A grant is only taken in REQ and never while a discarded response is still owed.
    assign gnt_ok   = (state == S_REQ) && !drop && mem_gnt;
    // The unit is never in WAIT with drop set, so every WAIT response is a real one.
    assign resp     = (state == S_WAIT) && mem_rvalid;
    assign deq      = (count != '0) && dispatch_ready;
    assign cnt_next = count + CNT_W'(resp) - CNT_W'(deq);
    // Space is judged after this cycle's enqueue/dequeue; no request is outstanding when used.
    assign space_ok = cnt_next < CNT_W'(QUEUE_DEPTH);
    assign opcode   = mem_rdata[6:0];

`ifdef JAL_EARLY_REDIRECT_EN
    logic                  is_jal;
    logic [20:0]           jimm_raw;
    logic [ADDR_WIDTH-1:0] jal_target;
    assign is_jal     = (opcode == 7'b1101111);
    assign blocks     = (opcode == 7'b1100011) || (opcode == 7'b1100111);
    assign jimm_raw   = {mem_rdata[31], mem_rdata[19:12], mem_rdata[20], mem_rdata[30:21], 1'b0};
    assign jal_target = req_pc + {{(ADDR_WIDTH-21){jimm_raw[20]}}, jimm_raw};
`else
    assign blocks = (opcode == 7'b1100011) || (opcode == 7'b1100111) || (opcode == 7'b1101111);
`endif

    assign mem_req       = (state == S_REQ) && !drop;
    assign mem_addr      = fetch_pc;
    assign decoderEnable = (count != '0);
    assign instToDecode  = decoderEnable ? q_inst[head] : NOP_INSTR;
    assign inst_PC       = decoderEnable ? q_pc[head] : '0;

    // Fetch FSM, fetch PC, drop flag and queue pointers; redirect overrides everything but reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
            drop     <= 1'b0;
            count    <= '0;
            head     <= '0;
            tail     <= '0;
        end else if (br_resolve) begin
            state    <= S_REQ;
            fetch_pc <= br_target;
            count    <= '0;
            head     <= '0;
            tail     <= '0;
            // A response still owed (or granted right now) belongs to the old path.
            drop     <= ((state == S_WAIT) && !mem_rvalid) || gnt_ok || (drop && !mem_rvalid);
        end else begin
            if (drop && mem_rvalid)
                drop <= 1'b0;
            if (resp)
                tail <= tail + PTR_W'(1);
            if (deq)
                head <= head + PTR_W'(1);
            count <= cnt_next;
            case (state)
                S_IDLE: begin
                    if (space_ok)
                        state <= S_REQ;
                end
                S_REQ: begin
                    if (gnt_ok) begin
                        req_pc   <= fetch_pc;
                        fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid) begin
                        if (blocks)
                            state <= S_BLOCKED;
`ifdef JAL_EARLY_REDIRECT_EN
                        else if (is_jal) begin
                            fetch_pc <= jal_target;
                            state    <= space_ok ? S_REQ : S_IDLE;
                        end
`endif
                        else
                            state <= space_ok ? S_REQ : S_IDLE;
                    end
                end
                default: begin
                    // BLOCKED: wait for the backend redirect
                end
            endcase
        end
    end

    // Queue storage; contents only matter below count, so no reset is needed.
    always_ff @(posedge clk) begin
        if (!rst && !br_resolve && resp) begin
            q_inst[tail] <= mem_rdata;
            q_pc[tail]   <= req_pc;
        end
    end
endmodule
